fp16_mul_arbiter: RTL and testbench
===================================

// Module: fp16_mul_arbiter
// PURPOSE
//   Shares one combinational half-precision (IEEE-754 binary16) multiplier among
//   NUM_REQ requesters. Round-robin arbitration, valid/ready on every side,
//   two-stage registered pipeline. Sits between the ALU issue logic and the
//   multiplier datapath; returns each product tagged with the requester id.
// PARAMETERS
//   NUM_REQ  4  number of requester ports (2..8)
//   ID_W     2  width of rsp_id; must equal clog2(NUM_REQ)
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous reset, active-high
//   req_valid  in   NUM_REQ      per-requester operand valid
//   req_a      in   16*NUM_REQ   operand A, requester i at [16*i+15:16*i]
//   req_b      in   16*NUM_REQ   operand B, same packing as req_a
//   req_ready  out  NUM_REQ      one-hot grant; transfer when valid&ready
//   rsp_valid  out  1            result valid
//   rsp_ready  in   1            consumer accepts result
//   rsp_data   out  16           binary16 product
//   rsp_id     out  ID_W         index of the requester that issued it
//   ops_done   out  16           count of accepted responses, wraps at 0xFFFF
// BEHAVIOUR
//   Reset: rsp_valid=0, rsp_data=0, rsp_id=0, ops_done=0, s1_valid=0,
//     rr_ptr=0 (requester 0 highest priority); req_ready=0 during rst.
//   Stages: S1 = operand register {a,b,id,s1_valid};
//     S2 = output register {rsp_data,rsp_id,rsp_valid}.
//   s2_adv = !rsp_valid | rsp_ready;  s1_adv = !s1_valid | s2_adv.
//   Grant (combinational): if s1_adv and any req_valid, pick the first valid
//     index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; assert only its
//     req_ready. req_ready never high for a non-valid requester, or while
//     !s1_adv.
//   On grant: S1 loads that requester's a/b/id, s1_valid=1;
//     rr_ptr <= (granted+1) mod NUM_REQ. No grant -> rr_ptr unchanged.
//   s1_adv with no grant: s1_valid <= 0.
//   s2_adv: rsp_valid<=s1_valid; if s1_valid, rsp_data<=mul(S1.a,S1.b),
//     rsp_id<=S1.id. rsp_data/rsp_id held stable while rsp_valid&!rsp_ready.
//   Latency: accept in cycle N -> rsp_valid in cycle N+2 (no backpressure).
//   Throughput: 1 op/cycle while rsp_ready=1.
//   Backpressure: rsp_ready=0 with both stages full -> all req_ready=0,
//     nothing dropped or duplicated.
//   Simultaneous rsp accept + new grant in the same cycle: both take effect.
//   ops_done += 1 on each rsp_valid&rsp_ready, 16-bit wrap.
//   Requester contract: hold req_valid, req_a, req_b stable until ready.
//   Arithmetic: product as defined by the team multiplier: sign XOR, biased
//     exponent add, normalise; any zero-exponent operand -> output 0x0000.
//     No rounding, no inf/NaN handling added here.
//   rst mid-operation: in-flight S1/S2 contents discarded, no response
//     emitted; first grant after reset follows rr_ptr=0.
//   State: per-slot handshake pipeline, not a named FSM; slot states EMPTY,
//     FULL, FULL_STALLED derived from valid/advance bits.
// STRUCTURE
//   Shared package fp16_pkg: FP16_W=16, EXP_W=5, MAN_W=10, BIAS=15,
//     FP16_ZERO=16'h0000, FP16_ONE=16'h3C00.
//   One sub-module: the existing combinational multiplier `mul` (a,b -> out),
//     instantiated between S1 and S2. Round-robin picker inlined (function).
// TESTING
//   1) Req0 a=0x3C00 b=0x4000 (1.0*2.0), rsp_ready=1 -> rsp 0x4000, id 0, N+2.
//   2) Req2 a=0x3E00 b=0x3E00 (1.5*1.5) -> rsp_data 0x4080, rsp_id 2.
//   3) Req1 a=0x0000 b=0xC000 -> rsp_data 0x0000 (zero rule), id 1.
//   4) All 4 valid continuously, rsp_ready=1 -> ids 0,1,2,3,0,1..., one per
//      cycle; ops_done=8 after 8 responses.
//   5) Stream active, rsp_ready=0 for 3 cycles -> rsp_data/id frozen,
//      req_ready=0 once S1 full, all products later delivered in order once.
//   6) rst high 1 cycle with S1 and S2 full -> next cycle rsp_valid=0,
//      ops_done=0, next grant to lowest valid index from 0.

Source files
------------

// File: rtl/fp16_mul_arbiter_pkg.sv
// Shared binary16 constants and the pipeline slot-state encoding used by the
// shared-multiplier arbiter and its multiplier datapath.
package fp16_pkg;

  localparam int FP16_W = 16;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;
  localparam int BIAS   = 15;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

  // EMPTY: no data; FULL: data moving on this cycle; FULL_STALLED: data held.
  typedef enum logic [1:0] {
    SLOT_EMPTY        = 2'd0,
    SLOT_FULL         = 2'd1,
    SLOT_FULL_STALLED = 2'd2
  } slot_state_e;

endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// Request/response bus between the ALU issue logic (master) and the shared
// binary16 multiplier arbiter (slave).
interface fp16_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import fp16_pkg::*;

  // Valid/ready: a beat transfers on a rising edge where valid and ready are
  // both high. A requester holds valid and its operands stable until ready;
  // ready never depends on anything but valid and the pipeline occupancy.
  logic [NUM_REQ-1:0]        req_valid;
  logic [FP16_W*NUM_REQ-1:0] req_a;
  logic [FP16_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [FP16_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic [15:0]               ops_done;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, ops_done
  );

endinterface

// File: rtl/fp16_mul_arbiter_mul.sv
// Team combinational binary16 multiplier: sign XOR, biased exponent add,
// one-step normalise, truncated mantissa, zero-exponent operand gives zero.
module mul
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic [FP16_W-1:0] out
);

  logic                 w_sign;
  logic [EXP_W-1:0]     w_ea;
  logic [EXP_W-1:0]     w_eb;
  logic [2*MAN_W+1:0]   w_prod;
  logic [2*MAN_W+1:0]   w_norm;
  logic [EXP_W-1:0]     w_exp;
  logic [MAN_W-1:0]     w_man;

  always_comb begin
    w_sign = a[FP16_W-1] ^ b[FP16_W-1];
    w_ea   = a[FP16_W-2:MAN_W];
    w_eb   = b[FP16_W-2:MAN_W];
    w_prod = (2*MAN_W+2)'({1'b1, a[MAN_W-1:0]}) * (2*MAN_W+2)'({1'b1, b[MAN_W-1:0]});
    // Significand product lies in [1,4); align its leading one to bit 21.
    w_norm = w_prod[2*MAN_W+1] ? w_prod : (w_prod << 1);
    w_man  = MAN_W'(w_norm >> (MAN_W + 1));
    w_exp  = w_ea + w_eb - EXP_W'(BIAS) + EXP_W'(w_prod[2*MAN_W+1]);
    if ((w_ea == '0) || (w_eb == '0)) begin
      out = FP16_ZERO;
    end else begin
      out = {w_sign, w_exp, w_man};
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter sharing one binary16 multiplier among NUM_REQ
// requesters through a two-slot (operand, result) valid/ready pipeline.
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  fp16_mul_arbiter_if.slave        bus,
  output slot_state_e              o_s1_state,
  output slot_state_e              o_s2_state
);

  // Returns {found, index}: first valid requester scanning from ptr upward.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] sel;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sel = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (valid[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  logic [FP16_W-1:0]  w_req_a [NUM_REQ];
  logic [FP16_W-1:0]  w_req_b [NUM_REQ];
  logic               w_s1_adv;
  logic               w_s2_adv;
  logic [ID_W:0]      w_pick;
  logic               w_any_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W-1:0]    w_next_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [FP16_W-1:0]  w_product;

  logic [ID_W-1:0]    r_rr_ptr;
  logic               r_s1_valid;
  logic [FP16_W-1:0]  r_s1_a;
  logic [FP16_W-1:0]  r_s1_b;
  logic [ID_W-1:0]    r_s1_id;
  logic               r_rsp_valid;
  logic [FP16_W-1:0]  r_rsp_data;
  logic [ID_W-1:0]    r_rsp_id;
  logic [15:0]        r_ops_done;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_a[i] = bus.req_a[FP16_W*i +: FP16_W];
      w_req_b[i] = bus.req_b[FP16_W*i +: FP16_W];
    end
  end

  assign w_s2_adv    = !r_rsp_valid || bus.rsp_ready;
  assign w_s1_adv    = !r_s1_valid || w_s2_adv;
  assign w_pick      = rr_pick(bus.req_valid, r_rr_ptr);
  assign w_any_grant = w_pick[ID_W] && w_s1_adv && !rst;
  assign w_grant_idx = w_pick[ID_W-1:0];
  assign w_next_ptr  = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  always_comb begin
    w_grant = '0;
    if (w_any_grant) w_grant[w_grant_idx] = 1'b1;
  end

  mul u_mul (
    .a   (r_s1_a),
    .b   (r_s1_b),
    .out (w_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_a      <= FP16_ZERO;
      r_s1_b      <= FP16_ZERO;
      r_s1_id     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= FP16_ZERO;
      r_rsp_id    <= '0;
      r_ops_done  <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_any_grant;
        if (w_any_grant) begin
          r_s1_a   <= w_req_a[w_grant_idx];
          r_s1_b   <= w_req_b[w_grant_idx];
          r_s1_id  <= w_grant_idx;
          r_rr_ptr <= w_next_ptr;
        end
      end
      // Result fields only move on a real handoff so a stalled beat stays frozen.
      if (w_s2_adv) begin
        r_rsp_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rsp_data <= w_product;
          r_rsp_id   <= r_s1_id;
        end
      end
      if (r_rsp_valid && bus.rsp_ready) r_ops_done <= r_ops_done + 16'd1;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.ops_done  = r_ops_done;

  always_comb begin
    o_s1_state = SLOT_EMPTY;
    if (r_s1_valid) o_s1_state = w_s2_adv ? SLOT_FULL : SLOT_FULL_STALLED;
    o_s2_state = SLOT_EMPTY;
    if (r_rsp_valid) o_s2_state = bus.rsp_ready ? SLOT_FULL : SLOT_FULL_STALLED;
  end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Self-checking bench for fp16_mul_arbiter: real-valued product model, an
// occupancy-based grant model and an in-order response scoreboard.
module tb_fp16_mul_arbiter;
  import fp16_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = FP16_W + ID_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp16_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();
  slot_state_e s1_state;
  slot_state_e s2_state;

  fp16_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_s1_state (s1_state),
    .o_s2_state (s2_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]       exp_q[$];
  int                 n_vec     = 0;
  int                 n_err     = 0;
  int                 ops_model = 0;
  int                 model_ptr = 0;
  bit                 mon_en    = 1'b0;
  logic [NUM_REQ-1:0] last_grant = '0;

  // ---------------- reference model ----------------
  function automatic real fp_mag(input logic [15:0] x);
    real v;
    int  e;
    v = 1.0 + real'(int'(x[9:0])) / 1024.0;
    e = int'(x[14:10]) - BIAS;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return v;
  endfunction

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    real         v;
    int          e;
    logic [15:0] r;
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return FP16_ZERO;
    v = fp_mag(a) * fp_mag(b);
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    r[15]    = a[15] ^ b[15];
    r[14:10] = 5'(e + BIAS);
    r[9:0]   = 10'($rtoi((v - 1.0) * 1024.0));
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v[15]    = 1'($urandom_range(0, 1));
    v[9:0]   = 10'($urandom_range(0, 1023));
    v[14:10] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(8, 22));
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_grant;
    logic [W-1:0]       e;
    int                 j;
    int                 gi;
    if (mon_en) begin
      exp_grant = '0;
      gi = 0;
      if (rst) begin
        n_vec++;
        if (bus.req_ready !== '0) begin
          n_err++;
          $display("FAIL rst_ready: got %b want 0", bus.req_ready);
        end
        exp_q.delete();
        ops_model  = 0;
        model_ptr  = 0;
        last_grant = '0;
      end else begin
        if (exp_q.size() < 2 || bus.rsp_ready) begin
          for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (model_ptr + k) % NUM_REQ;
            if (bus.req_valid[j]) begin exp_grant = '0; exp_grant[j] = 1'b1; gi = j; end
          end
        end
        n_vec++;
        if (bus.req_ready !== exp_grant) begin
          n_err++;
          $display("FAIL grant: got %b want %b (ptr %0d, inflight %0d)", bus.req_ready, exp_grant, model_ptr, exp_q.size());
        end
        n_vec++;
        if (bus.ops_done !== 16'(ops_model)) begin
          n_err++;
          $display("FAIL ops_done: got %0d want %0d", bus.ops_done, ops_model);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          n_vec++;
          ops_model++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: got id %0d data %h want no response", bus.rsp_id, bus.rsp_data);
          end else begin
            e = exp_q.pop_front();
            if ({bus.rsp_id, bus.rsp_data} !== e) begin
              n_err++;
              $display("FAIL rsp: got id %0d data %h want id %0d data %h", bus.rsp_id, bus.rsp_data, e[W-1:FP16_W], e[FP16_W-1:0]);
            end
          end
        end
        if (exp_grant != '0) begin
          exp_q.push_back({ID_W'(gi), ref_mul(bus.req_a[16*gi +: 16], bus.req_b[16*gi +: 16])});
          model_ptr = (gi + 1) % NUM_REQ;
        end
        last_grant = bus.req_ready & bus.req_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Per-requester: a pending request is held; an idle or just-granted slot
  // gets a fresh request with probability p_valid if enabled in mask.
  task automatic stream_cycle(input int p_valid, input bit rdy, input logic [NUM_REQ-1:0] mask);
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!bus.req_valid[i] || last_grant[i]) begin
        if (mask[i] && int'($urandom_range(0, 99)) < p_valid) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_a[16*i +: 16] = rand_op();
          bus.req_b[16*i +: 16] = rand_op();
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    bus.rsp_ready = rdy;
  endtask

  task automatic send_one(input int idx, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [15:0] d, output logic [ID_W-1:0] id,
                          output bit timeout);
    int k;
    timeout = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready           = 1'b1;
    bus.req_valid[idx]      = 1'b1;
    bus.req_a[16*idx +: 16] = a;
    bus.req_b[16*idx +: 16] = b;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.req_ready[idx] && k < 50);
    if (!bus.req_ready[idx]) timeout = 1'b1;
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 50);
    d  = bus.rsp_data;
    id = bus.rsp_id;
  endtask

  task automatic drain();
    int k;
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while ((exp_q.size() != 0 || bus.rsp_valid) && k < 40);
    n_vec++;
    if (exp_q.size() != 0 || bus.rsp_valid) begin
      n_err++;
      $display("FAIL drain: got %0d outstanding want 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;
    mon_en        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.ops_done} !== '0) begin
      n_err++;
      $display("FAIL reset_out: got v%b d%h id%0d ops%0d want all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.ops_done);
    end
    n_vec++;
    if (s1_state !== SLOT_EMPTY || s2_state !== SLOT_EMPTY) begin
      n_err++;
      $display("FAIL reset_slots: got %s/%s want SLOT_EMPTY", s1_state.name(), s2_state.name());
    end
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_directed();
    logic [15:0]     a_in [3] = '{16'h3C00, 16'h3E00, 16'h0000};
    logic [15:0]     b_in [3] = '{16'h4000, 16'h3E00, 16'hC000};
    int              rq   [3] = '{0, 2, 1};
    logic [15:0]     want [3] = '{16'h4000, 16'h4080, 16'h0000};
    int              lat;
    logic [15:0]     d;
    logic [ID_W-1:0] id;
    bit              to;
    for (int t = 0; t < 3; t++) begin
      send_one(rq[t], a_in[t], b_in[t], lat, d, id, to);
      n_vec++;
      if (to || lat != 2) begin
        n_err++;
        $display("FAIL latency_%0d: got %0d (timeout %0b) want 2", t, lat, to);
      end
      n_vec++;
      if (d !== want[t] || id !== ID_W'(rq[t])) begin
        n_err++;
        $display("FAIL directed_%0d: got id %0d data %h want id %0d data %h", t, id, d, rq[t], want[t]);
      end
    end
    drain();
  endtask

  task automatic test_round_robin();
    int seen;
    int cyc;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]      = 1'b1;
      bus.req_a[16*i +: 16] = rand_op();
      bus.req_b[16*i +: 16] = rand_op();
    end
    bus.rsp_ready = 1'b1;
    seen = 0;
    cyc  = 0;
    while (seen < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) begin
        n_vec++;
        if (bus.rsp_id !== ID_W'(seen % NUM_REQ)) begin
          n_err++;
          $display("FAIL rr_order: got id %0d want %0d", bus.rsp_id, seen % NUM_REQ);
        end
        seen++;
      end else if (seen > 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rr_gap: got bubble after %0d responses want one per cycle", seen);
      end
      stream_cycle(100, 1'b1, '1);
    end
    @(negedge clk);
    n_vec++;
    if (seen != 8 || bus.ops_done !== 16'd8) begin
      n_err++;
      $display("FAIL rr_count: got %0d responses ops_done %0d want 8/8", seen, bus.ops_done);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0]     d0;
    logic [ID_W-1:0] id0;
    repeat (6) stream_cycle(100, 1'b1, '1);
    stream_cycle(100, 1'b0, '1);
    @(negedge clk);
    d0  = bus.rsp_data;
    id0 = bus.rsp_id;
    n_vec++;
    if (!bus.rsp_valid || bus.req_ready !== '0) begin
      n_err++;
      $display("FAIL bp_enter: got rsp_valid %b req_ready %b want 1/0", bus.rsp_valid, bus.req_ready);
    end
    repeat (2) begin
      stream_cycle(100, 1'b0, '1);
      @(negedge clk);
      n_vec++;
      if (bus.rsp_data !== d0 || bus.rsp_id !== id0 || bus.req_ready !== '0) begin
        n_err++;
        $display("FAIL bp_hold: got id %0d data %h ready %b want id %0d data %h ready 0", bus.rsp_id, bus.rsp_data, bus.req_ready, id0, d0);
      end
      n_vec++;
      if (s1_state !== SLOT_FULL_STALLED || s2_state !== SLOT_FULL_STALLED) begin
        n_err++;
        $display("FAIL bp_slots: got %s/%s want SLOT_FULL_STALLED", s1_state.name(), s2_state.name());
      end
    end
    repeat (5) stream_cycle(100, 1'b1, '1);
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      stream_cycle(int'($urandom_range(20, 90)), ($urandom_range(0, 3) != 0), '1);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    repeat (4) stream_cycle(100, 1'b0, 4'b0100);
    @(negedge clk);
    n_vec++;
    if (s1_state !== SLOT_FULL_STALLED || s2_state !== SLOT_FULL_STALLED) begin
      n_err++;
      $display("FAIL mid_fill: got %s/%s want SLOT_FULL_STALLED", s1_state.name(), s2_state.name());
    end
    @(posedge clk); #1;
    rst           = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1010;
    bus.req_a[16*1 +: 16] = 16'h3C00;
    bus.req_b[16*1 +: 16] = 16'h4200;
    bus.req_a[16*3 +: 16] = 16'h4000;
    bus.req_b[16*3 +: 16] = 16'h4000;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.ops_done !== 16'd0) begin
      n_err++;
      $display("FAIL mid_rst: got rsp_valid %b ops_done %0d want 0/0", bus.rsp_valid, bus.ops_done);
    end
    n_vec++;
    if (bus.req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL mid_grant: got %b want 0010", bus.req_ready);
    end
    drain();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
